md_unit: RTL and testbench

//  Multi-cycle multiply/divide unit with HI/LO registers for the E stage of the 5-stage pipeline.
//  - Accepts one operation per start pulse from E-stage control.
//  - Runs a fixed-latency cycle counter to model mult/div delay.
//  - Drives busy to the stall unit, which holds MD-class instructions in D while (start | busy).
//  - HI/LO are read combinationally by E-stage mfhi/mflo; results forward like any other E source.

---
 rtl/md_unit.sv | 184 ++++++++++++++++++
 tb/tb_md_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// One operation is accepted per start pulse while idle; busy stays high for a fixed
// number of cycles and HI/LO are committed on the edge where busy falls.
// mthi/mtlo write HI/LO directly on the start edge without going busy.
// A start that arrives while busy is ignored, including mthi/mtlo.
// Optional feature macro: MD_UNIT_MADD_EN enables madd/maddu/msub/msubu (ops 7..10),
// which accumulate into {HI,LO}. Without it, ops 7..10 behave as unknown no-ops.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   // The counter is loaded with N-1 so that busy covers exactly N cycles.
   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic [63:0] acc;
   logic [63:0] res;

   // Signed 32x32 -> 64 product.
   function automatic logic signed [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
   endfunction

   // Unsigned 32x32 -> 64 product.
   function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
      return {32'd0, a} * {32'd0, b};
   endfunction

   // Signed divide on magnitudes: quotient truncates toward zero, remainder follows
   // the dividend sign. Working on magnitudes keeps 0x80000000 / -1 well defined
   // (it wraps to 0x80000000 with remainder 0). Returns {remainder, quotient}.
   function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ua, ub, uq, ur, q, r;
      ua = a[31] ? (~a + 32'd1) : a;
      ub = b[31] ? (~b + 32'd1) : b;
      uq = ua / ub;
      ur = ua % ub;
      q  = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
      r  = a[31] ? (~ur + 32'd1) : ur;
      return {r, q};
   endfunction

   // Operations that go busy for MULT_CYCLES.
   function automatic logic is_mult_op(input logic [3:0] o);
`ifdef MD_UNIT_MADD_EN
      return (o == OP_MULT) || (o == OP_MULTU) || ((o >= OP_MADD) && (o <= OP_MSUBU));
`else
      return (o == OP_MULT) || (o == OP_MULTU);
`endif
   endfunction

   // Operations that go busy for DIV_CYCLES.
   function automatic logic is_div_op(input logic [3:0] o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

   assign acc = {hi_q, lo_q};

   // Result to commit at the end of RUN; divide by zero leaves HI/LO untouched.
   always_comb begin
      res = acc;
      case (op_q)
         OP_MULT:  res = mul_s(a_q, b_q);
         OP_MULTU: res = mul_u(a_q, b_q);
         OP_DIV:   if (b_q != 32'd0) res = div_s(a_q, b_q);
         OP_DIVU:  if (b_q != 32'd0) res = {a_q % b_q, a_q / b_q};
`ifdef MD_UNIT_MADD_EN
         OP_MADD:  res = acc + mul_s(a_q, b_q);
         OP_MADDU: res = acc + mul_u(a_q, b_q);
         OP_MSUB:  res = acc - mul_s(a_q, b_q);
         OP_MSUBU: res = acc - mul_u(a_q, b_q);
`endif
         default:  res = acc;
      endcase
   end

   // Next-state logic: accept/launch in IDLE, count down and commit in RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (is_mult_op(op) || is_div_op(op)) begin
                  op_d    = op;
                  a_d     = A;
                  b_d     = B;
                  cnt_d   = is_div_op(op) ? DIV_LOAD : MULT_LOAD;
                  busy_d  = 1'b1;
                  state_d = S_RUN;
               end else if (op == OP_MTHI) begin
                  hi_d = A;
               end else if (op == OP_MTLO) begin
                  lo_d = A;
               end
            end
         end
         S_RUN: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               hi_d    = res[63:32];
               lo_d    = res[31:0];
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers; asynchronous reset discards any in-flight operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         op_q    <= 4'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized bench for md_unit against an arithmetic model.
module tb_md_unit;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;
`ifdef MD_UNIT_MADD_EN
   localparam bit MADD_ON = 1'b1;
`else
   localparam bit MADD_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Cycles busy for an op; 0 means it completes (or does nothing) at the start edge.
   function automatic int lat(input logic [3:0] o);
      if (o == 4'd1 || o == 4'd2) return MULT_N;
      if (o == 4'd3 || o == 4'd4) return DIV_N;
      if (MADD_ON && o >= 4'd7 && o <= 4'd10) return MULT_N;
      return 0;
   endfunction

   // Architectural effect of one accepted operation on HI/LO.
   task automatic model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          p;
      longint unsigned up;
      int              sa, sb;
      p  = longint'($signed(a)) * longint'($signed(b));
      up = {32'd0, a} * {32'd0, b};
      sa = a;
      sb = b;
      case (o)
         4'd1: {m_hi, m_lo} = p;
         4'd2: {m_hi, m_lo} = up;
         4'd3: if (b != 0) begin
                  if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                     m_lo = 32'h8000_0000; m_hi = 32'd0;
                  end else begin
                     m_lo = sa / sb; m_hi = sa % sb;
                  end
               end
         4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
         4'd5: m_hi = a;
         4'd6: m_lo = a;
         4'd7: if (MADD_ON) {m_hi, m_lo} = {m_hi, m_lo} + p;
         4'd8: if (MADD_ON) {m_hi, m_lo} = {m_hi, m_lo} + up;
         4'd9: if (MADD_ON) {m_hi, m_lo} = {m_hi, m_lo} - p;
         4'd10: if (MADD_ON) {m_hi, m_lo} = {m_hi, m_lo} - up;
         default: ;
      endcase
   endtask

   // Issue one op; optionally inject an illegal mthi while busy. Ends at a negedge.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
      int n;
      logic [31:0] ohi, olo;
      n   = lat(o);
      ohi = m_hi;
      olo = m_lo;
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0; op = 4'($urandom); A = $urandom; B = $urandom;
      if (n == 0) begin
         model_apply(o, a, b);
         @(negedge clk);
         check("imm_busy", busy, 0);
         check("imm_hi", HI, m_hi);
         check("imm_lo", LO, m_lo);
      end else begin
         for (int i = 0; i < n; i++) begin
            if (inject && i == 1) begin start = 1'b1; op = 4'd5; A = 32'hDEAD_BEEF; end
            @(negedge clk);
            check("run_busy", busy, 1);
            check("run_hi_hold", HI, ohi);
            check("run_lo_hold", LO, olo);
            @(posedge clk); #1;
            start = 1'b0;
         end
         model_apply(o, a, b);
         @(negedge clk);
         check("done_busy", busy, 0);
         check("done_hi", HI, m_hi);
         check("done_lo", LO, m_lo);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      reset = 1'b1; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_hi", HI, 0);
      check("rst_lo", LO, 0);

      // Reset mid-divide, at cycle 4 of 10.
      issue(4'd5, 32'h55, 32'd0, 0);
      issue(4'd6, 32'h66, 32'd0, 0);
      start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_hi", HI, 0);
      check("midrst_lo", LO, 0);
      m_hi = 32'd0; m_lo = 32'd0;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      issue(4'd4, 32'd7, 32'd2, 0);
      check("divu_hi_c", HI, 32'd1);
      check("divu_lo_c", LO, 32'd3);

      // mult -2 * 3
      issue(4'd1, 32'hFFFF_FFFE, 32'd3, 0);
      check("mult_hi_c", HI, 32'hFFFF_FFFF);
      check("mult_lo_c", LO, 32'hFFFF_FFFA);

      // div -7 / 2
      issue(4'd3, 32'hFFFF_FFF9, 32'd2, 0);
      check("div_hi_c", HI, 32'hFFFF_FFFF);
      check("div_lo_c", LO, 32'hFFFF_FFFD);

      // Overflow divide
      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("divovf_hi_c", HI, 32'd0);
      check("divovf_lo_c", LO, 32'h8000_0000);

      // Divide by zero leaves preloaded HI/LO
      issue(4'd5, 32'h11, 32'd0, 0);
      issue(4'd6, 32'h22, 32'd0, 0);
      issue(4'd3, 32'd1234, 32'd0, 0);
      check("dz_hi_c", HI, 32'h11);
      check("dz_lo_c", LO, 32'h22);
      issue(4'd4, 32'd99, 32'd0, 0);
      check("dzu_hi_c", HI, 32'h11);

      // Back-to-back mthi/mtlo
      issue(4'd5, 32'd5, 32'd0, 0);
      issue(4'd6, 32'd6, 32'd0, 0);
      check("b2b_hi_c", HI, 32'd5);
      check("b2b_lo_c", LO, 32'd6);

      // Start while busy is ignored
      issue(4'd2, 32'd10, 32'd20, 1);
      check("inj_hi_c", HI, 32'd0);
      check("inj_lo_c", LO, 32'd200);

      // Unknown ops
      issue(4'd0, 32'hAAAA_AAAA, 32'd1, 0);
      issue(4'd15, 32'hAAAA_AAAA, 32'd1, 0);
      check("unk_lo_c", LO, 32'd200);

      // maddu accumulate (or no-op without the feature)
      issue(4'd5, 32'd0, 32'd0, 0);
      issue(4'd6, 32'hFFFF_FFFF, 32'd0, 0);
      issue(4'd8, 32'd1, 32'd1, 0);
      check("maddu_hi_c", HI, MADD_ON ? 32'd1 : 32'd0);
      check("maddu_lo_c", LO, MADD_ON ? 32'd0 : 32'hFFFF_FFFF);

      // Randomized operations against the model
      for (int k = 0; k < 60; k++) begin
         ro = 4'($urandom_range(0, 15));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 17); end
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: rb = -($urandom_range(1, 9));
            default: ;
         endcase
         issue(ro, ra, rb, ($urandom_range(0, 4) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
